// File: rtl/ms7210_iic_master.sv
// Byte-level I2C master for MS7210 single-register accesses (16-bit address, one data byte).
// Define IIC_NACK_ABORT_EN to end a frame with STOP as soon as the slave NACKs.
`timescale 1ns / 1ps
module ms7210_iic_master #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  device_id,
  input  logic        iic_trig,
  input  logic        w_r,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        byte_over,
  output logic [7:0]  data_out,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int unsigned QDIV = CLK_FREQ / (SCL_FREQ * 4);
  localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLast = QW'(QDIV - 1);

`ifdef IIC_NACK_ABORT_EN
  localparam bit AbortOnNack = 1'b1;
`else
  localparam bit AbortOnNack = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StTxByte,
    StRxAck,
    StRestart,
    StRxByte,
    StTxNack,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic [6:0]    dev_q, dev_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rd_phase_q, rd_phase_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          byte_over_q, byte_over_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic [1:0]    sda_sync_q;

  logic       accept, tick, bit_end, sample, sda_in;
  logic [7:0] next_byte;
  logic       unused_dev0;

  // R/W bit always replaces device_id[0].
  assign unused_dev0 = device_id[0];

  assign accept  = iic_trig & ~busy_q;
  assign tick    = busy_q & (qcnt_q == QLast);
  assign bit_end = tick & (quarter_q == 2'd3);
  assign sample  = tick & (quarter_q == 2'd2);
  assign sda_in  = sda_sync_q[1];

  always_comb begin
    unique case (byte_cnt_q)
      2'd0:    next_byte = addr_q[15:8];
      2'd1:    next_byte = addr_q[7:0];
      default: next_byte = data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    quarter_d   = quarter_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    dev_d       = dev_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_phase_d  = rd_phase_q;
    nack_d      = nack_q;
    busy_d      = busy_q;
    byte_over_d = 1'b0;
    data_out_d  = data_out_q;
    ack_err_d   = ack_err_q;
    scl_d       = 1'b1;
    sda_oe_d    = 1'b0;

    if (accept) begin
      qcnt_d    = '0;
      quarter_d = 2'd0;
    end else if (busy_q) begin
      qcnt_d = tick ? '0 : qcnt_q + QW'(1);
      if (tick) quarter_d = quarter_q + 2'd1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          dev_d      = device_id[7:1];
          wr_d       = w_r;
          addr_d     = addr;
          data_d     = data_in;
          busy_d     = 1'b1;
          ack_err_d  = 1'b0;
          byte_cnt_d = 2'd0;
          rd_phase_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          shift_d   = {dev_q, 1'b0};
          bit_cnt_d = 3'd0;
          state_d   = StTxByte;
        end
      end
      StTxByte: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = StRxAck;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StRxAck: begin
        if (sample) nack_d = sda_in;
        if (bit_end) begin
          ack_err_d = ack_err_q | nack_q;
          if (AbortOnNack && nack_q) begin
            state_d = StStop;
          end else if (rd_phase_q) begin
            bit_cnt_d = 3'd0;
            state_d   = StRxByte;
          end else if (!wr_q && byte_cnt_q == 2'd2) begin
            state_d = StRestart;
          end else if (byte_cnt_q == 2'd3) begin
            byte_over_d = 1'b1;
            state_d     = StStop;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = next_byte;
            bit_cnt_d  = 3'd0;
            state_d    = StTxByte;
          end
        end
      end
      StRestart: begin
        if (bit_end) begin
          shift_d    = {dev_q, 1'b1};
          bit_cnt_d  = 3'd0;
          rd_phase_d = 1'b1;
          state_d    = StTxByte;
        end
      end
      StRxByte: begin
        if (sample) rx_d = {rx_q[6:0], sda_in};
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            data_out_d = rx_q;
            state_d    = StTxNack;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StTxNack: begin
        if (bit_end) begin
          byte_over_d = 1'b1;
          state_d     = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pins are decoded from next-state values so the registered outputs line up with the quarters.
    case (state_d)
      StIdle: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
      StStart: begin
        scl_d    = 1'b1;
        sda_oe_d = quarter_d[1];
      end
      StTxByte: begin
        scl_d    = quarter_d[1];
        sda_oe_d = ~shift_d[7];
      end
      StRestart: begin
        scl_d    = quarter_d[1];
        sda_oe_d = (quarter_d == 2'd3);
      end
      StStop: begin
        scl_d    = quarter_d[1];
        sda_oe_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_d    = quarter_d[1];
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      qcnt_q      <= '0;
      quarter_q   <= 2'd0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      dev_q       <= 7'h00;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      rd_phase_q  <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      byte_over_q <= 1'b0;
      data_out_q  <= 8'h00;
      ack_err_q   <= 1'b0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      sda_sync_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      quarter_q   <= quarter_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      dev_q       <= dev_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_phase_q  <= rd_phase_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      byte_over_q <= byte_over_d;
      data_out_q  <= data_out_d;
      ack_err_q   <= ack_err_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
      sda_sync_q  <= {sda_sync_q[0], sda};
    end
  end

  assign busy      = busy_q;
  assign byte_over = byte_over_q;
  assign data_out  = data_out_q;
  assign ack_err   = ack_err_q;
  assign scl       = scl_q;
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ms7210_iic_master.sv
// Directed bench for ms7210_iic_master with a behavioural I2C slave on a pulled-up SDA line.
`timescale 1ns / 1ps
module tb_ms7210_iic_master;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned SCL_FREQ = 100_000;
  localparam int BITCLK = 4 * (CLK_FREQ / (SCL_FREQ * 4));
  localparam int WR_LEN = 38 * BITCLK;
  localparam int RD_LEN = 48 * BITCLK;
  localparam int AB_LEN = 29 * BITCLK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  device_id = 8'h00;
  logic        iic_trig = 1'b0;
  logic        w_r = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        busy, byte_over, ack_err, scl;
  logic [7:0]  data_out;
  wire         sda_w;
  logic        slv_drv = 1'b0;

  assign sda_w = slv_drv ? 1'b0 : 1'bz;
  pullup (sda_w);

  ms7210_iic_master #(
    .CLK_FREQ(CLK_FREQ),
    .SCL_FREQ(SCL_FREQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .device_id(device_id),
    .iic_trig (iic_trig),
    .w_r      (w_r),
    .addr     (addr),
    .data_in  (data_in),
    .busy     (busy),
    .byte_over(byte_over),
    .data_out (data_out),
    .ack_err  (ack_err),
    .scl      (scl),
    .sda      (sda_w)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_fail = 0;
  int         n_bo = 0, n_start = 0, n_stop = 0, n_busy = 0;
  int         b_log, b_bo, b_st, b_sp, b_busy;
  int         nack_at = -1;
  logic [7:0] log_q[$];
  logic [7:0] dout_at_bo = 8'h00;
  logic [7:0] slv_data = 8'h5A;
  logic       last_mack = 1'b0;

  // Slave and bus monitor: start/stop counts double as the SDA-stable-while-SCL-high check.
  initial begin : monitor
    logic pscl, psda, rcv, skip, first, rd;
    logic [7:0] sh;
    int bitn;
    pscl = 1'b1; psda = 1'b1; rcv = 1'b1; skip = 1'b0; first = 1'b0; rd = 1'b0;
    sh = 8'h00; bitn = 0;
    forever begin
      @(negedge clk);
      if (busy) n_busy++;
      if (byte_over) begin
        n_bo++;
        dout_at_bo = data_out;
      end
      if (scl && pscl && psda && !sda_w) begin
        n_start++;
        bitn = 0; rcv = 1'b1; skip = 1'b1; first = 1'b1; rd = 1'b0; slv_drv = 1'b0;
      end else if (scl && pscl && !psda && sda_w) begin
        n_stop++;
      end
      if (scl && !pscl) begin
        if (bitn < 8 && rcv) sh = {sh[6:0], sda_w};
        if (bitn == 8 && !rcv) last_mack = sda_w;
      end
      if (!scl && pscl) begin
        if (skip) begin
          skip = 1'b0;
        end else begin
          bitn++;
          if (bitn == 8) begin
            if (rcv) begin
              if (first) rd = sh[0];
              slv_drv = (log_q.size() != nack_at);
              log_q.push_back(sh);
            end else begin
              slv_drv = 1'b0;
            end
          end else if (bitn == 9) begin
            bitn = 0;
            if (first && rd) begin
              rcv = 1'b0;
              slv_drv = ~slv_data[7];
            end else begin
              rcv = 1'b1;
              slv_drv = 1'b0;
            end
            first = 1'b0;
          end else if (!rcv) begin
            slv_drv = ~slv_data[7-bitn];
          end
        end
      end
      pscl = scl;
      psda = sda_w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] dev, input logic wr, input logic [15:0] a,
                             input logic [7:0] d);
    b_log = log_q.size(); b_bo = n_bo; b_st = n_start; b_sp = n_stop; b_busy = n_busy;
    device_id = dev; w_r = wr; addr = a; data_in = d; iic_trig = 1'b1;
    @(negedge clk);
    iic_trig = 1'b0; device_id = 8'h00; w_r = ~wr; addr = ~a; data_in = ~d;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    chk({tag, "_nbytes"}, log_q.size() - b_log, 4);
    chk({tag, "_dev"}, {24'd0, log_q[b_log]}, 32'hB2);
    chk({tag, "_ahi"}, {24'd0, log_q[b_log+1]}, {24'd0, a[15:8]});
    chk({tag, "_alo"}, {24'd0, log_q[b_log+2]}, {24'd0, a[7:0]});
    chk({tag, "_data"}, {24'd0, log_q[b_log+3]}, {24'd0, d});
    chk({tag, "_byte_over"}, n_bo - b_bo, 1);
    chk({tag, "_starts"}, n_start - b_st, 1);
    chk({tag, "_stops"}, n_stop - b_sp, 1);
    chk({tag, "_busy_len"}, n_busy - b_busy, WR_LEN);
    chk({tag, "_ack_err"}, {31'd0, ack_err}, 32'd0);
  endtask

  initial begin : stim
    int k;
    logic [15:0] a;
    logic [7:0]  d;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, sda_w}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_over", {31'd0, byte_over}, 32'd0);
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    start_frame(8'hB2, 1'b1, 16'h0003, 8'h5A);
    wait_done("wr");
    check_write("wr", 16'h0003, 8'h5A);

    start_frame(8'hB2, 1'b0, 16'h0003, 8'hEE);
    wait_done("rd");
    chk("rd_nbytes", log_q.size() - b_log, 4);
    chk("rd_dev_w", {24'd0, log_q[b_log]}, 32'hB2);
    chk("rd_ahi", {24'd0, log_q[b_log+1]}, 32'h00);
    chk("rd_alo", {24'd0, log_q[b_log+2]}, 32'h03);
    chk("rd_dev_r", {24'd0, log_q[b_log+3]}, 32'hB3);
    chk("rd_starts", n_start - b_st, 2);
    chk("rd_stops", n_stop - b_sp, 1);
    chk("rd_byte_over", n_bo - b_bo, 1);
    chk("rd_dout_at_bo", {24'd0, dout_at_bo}, 32'h5A);
    chk("rd_dout", {24'd0, data_out}, 32'h5A);
    chk("rd_master_nack", {31'd0, last_mack}, 32'd1);
    chk("rd_busy_len", n_busy - b_busy, RD_LEN);
    chk("rd_ack_err", {31'd0, ack_err}, 32'd0);

    // Trigger on the last busy cycle must be dropped; data_out survives a write.
    start_frame(8'hB3, 1'b1, 16'h0010, 8'h77);
    repeat (WR_LEN - 1) @(negedge clk);
    chk("fall_busy_last", {31'd0, busy}, 32'd1);
    iic_trig = 1'b1;
    @(negedge clk);
    iic_trig = 1'b0;
    chk("fall_trig_ignored", {31'd0, busy}, 32'd0);
    check_write("fall", 16'h0010, 8'h77);
    chk("fall_dout_held", {24'd0, data_out}, 32'h5A);

    nack_at = log_q.size() + 2;
    start_frame(8'hB2, 1'b1, 16'h0420, 8'h99);
    wait_done("nack");
    nack_at = -1;
`ifdef IIC_NACK_ABORT_EN
    chk("nack_nbytes", log_q.size() - b_log, 3);
    chk("nack_byte_over", n_bo - b_bo, 0);
    chk("nack_busy_len", n_busy - b_busy, AB_LEN);
`else
    chk("nack_nbytes", log_q.size() - b_log, 4);
    chk("nack_data", {24'd0, log_q[b_log+3]}, 32'h99);
    chk("nack_byte_over", n_bo - b_bo, 1);
    chk("nack_busy_len", n_busy - b_busy, WR_LEN);
`endif
    chk("nack_stops", n_stop - b_sp, 1);
    chk("nack_ack_err", {31'd0, ack_err}, 32'd1);

    for (int i = 0; i < 49; i++) begin
      a = 16'(i * 257 + 64);
      d = 8'(i * 37 + 5);
      start_frame(8'hB2, 1'b1, a, d);
      repeat (100) @(negedge clk);
      iic_trig = 1'b1; addr = 16'hFFFF; data_in = 8'h00; w_r = 1'b0;
      @(negedge clk);
      iic_trig = 1'b0;
      wait_done("b2b");
      check_write("b2b", a, d);
    end

    start_frame(8'hB2, 1'b1, 16'h1234, 8'hC3);
    k = 0;
    while (log_q.size() < b_log + 3 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach_data", log_q.size() - b_log, 3);
    repeat (3 * BITCLK + 2) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", {31'd0, scl}, 32'd1);
    chk("mid_rst_sda", {31'd0, sda_w}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_byte_over", {31'd0, byte_over}, 32'd0);
    chk("mid_rst_dout", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_frame(8'hB3, 1'b1, 16'h00A5, 8'h3C);
    wait_done("post");
    check_write("post", 16'h00A5, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ms7210_iic_master.md
# ms7210_iic_master

Byte-level I2C master that executes the single-register transactions requested by the MS7210 configuration sequencer. Each transaction uses a 16-bit register address and one data byte, either written or read back. The block sits directly downstream of the sequencer: it takes `device_id`, `addr`, `data_in` and `w_r` on an `iic_trig` pulse. It returns `busy`, `byte_over` and `data_out`, and drives the open-drain SCL/SDA pins of the HDMI transmitter.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `SCL_FREQ`, default 100_000: SCL frequency in Hz.
- `QDIV` (localparam) = CLK_FREQ/(SCL_FREQ*4): clocks per quarter SCL period. Default value is 125.
- `clk`  in  1  system clock; the block is fully synchronous to `clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `device_id`  in  8  8-bit bus address (0xB2). Bit 0 is ignored and replaced by the R/W bit.
- `iic_trig`  in  1  one-cycle start request. Ignored while `busy`=1.
- `w_r`  in  1  1 = write, 0 = read.
- `addr`  in  16  register address, sent MSB byte first.
- `data_in`  in  8  write data.
- `busy`  out  1  high while a transaction is in progress.
- `byte_over`  out  1  one-cycle pulse, exactly once per transaction, when the data byte and its ACK bit complete.
- `data_out`  out  8  last byte read from the slave.
- `ack_err`  out  1  set when the slave NACKs any byte. Cleared on the next accepted `iic_trig`.
- `scl`  out  1  SCL pin; driven 0/1, 1 at idle.
- `sda`  inout  1  open-drain SDA. Driven to 0 or released to 'z'; never driven to 1.

## Operation
- **Trigger capture.** On `iic_trig` with `busy`=0:
  - `device_id`, `w_r`, `addr` and `data_in` are latched into shadow registers.
  - `busy`=1 from the next cycle.
  - Inputs may change afterwards without effect.
- **Write frame:** START; {dev[7:1],0}; ACK; addr[15:8]; ACK; addr[7:0]; ACK; data; ACK; STOP.
- **Read frame:** START; {dev[7:1],0}; ACK; addr[15:8]; ACK; addr[7:0]; ACK; repeated START; {dev[7:1],1}; ACK; 8 data bits read; master NACK (SDA released); STOP.
- **State machine:** IDLE → START → TX_BYTE → RX_ACK, with a byte counter 0..3.
  - Write path: RX_ACK after byte 3 → STOP.
  - Read path: RX_ACK after byte 2 → RESTART → TX_BYTE (address + R) → RX_ACK → RX_BYTE → TX_NACK → STOP.
  - STOP → IDLE.
- **Shifting.** Bits are sent and received MSB first. `data_out` is loaded only at the end of RX_BYTE, and holds its value across write transactions.
- **byte_over.** Pulses at the end of RX_ACK for the write data byte, or at the end of TX_NACK for a read. This is always before STOP, so the sequencer can update `addr`/`data_in` before `busy` falls.
- **NACK handling.** A slave NACK sets `ack_err`. Behaviour after that depends on the Configuration macro.
- **Reset.** Assertion at any time, including mid-frame, forces:
  - `scl`=1, `sda`='z', `busy`=0, `byte_over`=0, `data_out`=0x00, `ack_err`=0.
  - state IDLE.

  No STOP is generated on reset.

## Timing
- A quarter tick fires every QDIV clocks; the counter is cleared on trigger.
- One bit period is 4 quarters:
  - q0: SCL low; SDA updated at the start of q0.
  - q1: SCL low.
  - q2, q3: SCL high.
  - SDA is sampled at the start of q3.
- **START:** SDA high / SCL high for q0–q1, then SDA low for q2–q3 with SCL high.
- **RESTART:** SCL low and SDA released for q0–q1, then SCL high for q2, then SDA low at q3.
- **STOP:** SDA low for q0–q1 (SCL low then high from q2), SDA released at q3. `busy` falls at the end of q3.
- **Frame lengths:**
  - Write: 38 bit periods (1 + 4×9 + 1). With defaults, that is 19000 clocks from trigger to `busy` low.
  - Read: 48 bit periods (1 + 3×9 + 1 + 9 + 9 + 1).
- **Latency.** `busy` rises 1 clock after `iic_trig`. A new `iic_trig` is accepted in the same cycle `busy` is 0.
- **Simultaneous events.** `iic_trig` in the cycle `busy` falls is ignored. The trigger is accepted one cycle later.

## Configuration
- Macro `IIC_NACK_ABORT_EN`.
- **Defined:** a NACK in any RX_ACK goes straight to STOP.
  - `byte_over` is not pulsed.
  - `ack_err`=1.
  - `busy` falls after that STOP.
- **Undefined:** the frame always runs to completion.
  - `ack_err` records the NACK.
  - `byte_over` pulses normally.

## Test plan
- Write, device 0xB2, addr 0x0003, data 0x5A, slave ACKs all bytes:
  - SDA bytes B2, 00, 03, 5A.
  - 1 `byte_over` pulse.
  - `busy` high 19000 clocks.
  - `ack_err`=0.
- Read of addr 0x0003, slave returns 0x5A:
  - Bytes B2, 00, 03, repeated START, B3.
  - `data_out`=0x5A before `busy` falls.
  - Master NACK observed.
- Slave NACKs the addr[7:0] byte:
  - Macro undefined: full 38-bit frame, `ack_err`=1, `byte_over` pulsed.
  - Macro defined: STOP right after that ACK slot, no `byte_over`, `ack_err`=1.
- Back-to-back sequence: `iic_trig` on the cycle after `busy` falls, repeated 49 times with changing addr/data. Required response:
  - Each frame carries the values latched at its trigger.
  - Extra `iic_trig` pulses during `busy` are ignored.
- `rst_n` low mid data byte:
  - Outputs immediately `scl`=1, `sda`=z, `busy`=0.
  - Next trigger runs a clean frame.
- Protocol monitor over all frames: SDA changes only while SCL is low, except during START/RESTART/STOP.
